// File: rtl/tanh_req_sched.sv
// tanh_req_sched: round-robin sharing of one combinational tanh unit between NUM_REQ requesters.
// S1 holds the granted operand that drives the unit; S2 holds the unit's result until the consumer takes it.
module tanh_req_sched #(
    parameter int NUM_REQ = 4,
    parameter int IN_W = 16,
    parameter int OUT_W = 8,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*IN_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [IN_W-1:0]         tanh_in_o,
    input  logic [OUT_W-1:0]        tanh_out_i,
    output logic                    rsp_valid_o,
    output logic [OUT_W-1:0]        rsp_data_o,
    output logic [ID_W-1:0]         rsp_id_o,
    input  logic                    rsp_ready_i,
    output logic                    busy_o
);
    logic              s1_vld;
    logic              s2_vld;
    logic [IN_W-1:0]   s1_data;
    logic [ID_W-1:0]   s1_id;
    logic [OUT_W-1:0]  s2_data;
    logic [ID_W-1:0]   s2_id;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   nxt_ptr;
    logic [ID_W-1:0]   idx;
    logic [ID_W:0]     sum;
    logic [IN_W-1:0]   gnt_data;
    logic              found;
    logic              s2_free;
    logic              s1_adv;
    logic              s1_free;
    logic              grant;

    assign s2_free = !s2_vld || rsp_ready_i;
    assign s1_adv  = s1_vld && s2_free;
    assign s1_free = !s1_vld || s1_adv;

    // Search rr_ptr, rr_ptr+1, ... with a single conditional wrap since both terms are below NUM_REQ.
    always_comb begin
        found    = 1'b0;
        gnt_id   = '0;
        gnt_data = '0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            idx = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : sum[ID_W-1:0];
            if (!found && req_valid_i[idx]) begin
                found    = 1'b1;
                gnt_id   = idx;
                gnt_data = req_data_i[int'(idx)*IN_W +: IN_W];
            end
        end
    end

    // Gating with rst_ni keeps every grant low while reset is held, not just after the first edge.
    assign grant       = found && s1_free && rst_ni;
    assign req_ready_o = grant ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id : '0;
    assign nxt_ptr     = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_id   <= '0;
            s2_vld  <= 1'b0;
            s2_data <= '0;
            s2_id   <= '0;
            rr_ptr  <= '0;
        end else begin
            if (grant) begin
                s1_vld  <= 1'b1;
                s1_data <= gnt_data;
                s1_id   <= gnt_id;
                rr_ptr  <= nxt_ptr;
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end
            if (s1_adv) begin
                s2_vld  <= 1'b1;
                s2_data <= tanh_out_i;
                s2_id   <= s1_id;
            end else if (rsp_ready_i) begin
                s2_vld <= 1'b0;
            end
        end
    end

    assign tanh_in_o   = s1_data;
    assign rsp_valid_o = s2_vld;
    assign rsp_data_o  = s2_data;
    assign rsp_id_o    = s2_id;
    assign busy_o      = s1_vld || s2_vld;
endmodule

// File: tb/tb_tanh_req_sched.sv
// tb_tanh_req_sched: directed scenarios plus random traffic against an in-order queue model of the scheduler.
module tb_tanh_req_sched;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [3:0]  req_valid_i;
    logic [63:0] req_data_i;
    logic [3:0]  req_ready_o;
    logic [15:0] tanh_in_o;
    logic [7:0]  tanh_out_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic [1:0]  rsp_id_o;
    logic        rsp_ready_i;
    logic        busy_o;

    int n_cmp = 0;
    int n_fail = 0;

    int         q_id[$];
    logic [7:0] q_dat[$];
    bit         s2_full;
    int         ptr;
    int         exp_grant;
    bit         m_adv;
    logic [3:0] exp_ready;

    always #5 clk_i = ~clk_i;

    // Stand-in for tanh_appr_16: the result is the operand's upper byte.
    assign tanh_out_i = tanh_in_o[15:8];

    tanh_req_sched dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .tanh_in_o(tanh_in_o), .tanh_out_i(tanh_out_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o),
        .rsp_ready_i(rsp_ready_i), .busy_o(busy_o)
    );

    function automatic logic [7:0] f_tanh(input logic [15:0] x);
        return x[15:8];
    endfunction

    task automatic model_reset;
        q_id.delete();
        q_dat.delete();
        s2_full = 1'b0;
        ptr = 0;
        exp_grant = -1;
        m_adv = 1'b0;
    endtask

    // Drive one cycle's inputs at the falling edge and derive what the outputs must be this cycle.
    task automatic setup(input logic [3:0] v, input logic [63:0] d, input logic r);
        int s1_occ;
        bit s1_free;
        @(negedge clk_i);
        req_valid_i = v;
        req_data_i  = d;
        rsp_ready_i = r;
        #1;
        s1_occ  = q_id.size() - int'(s2_full);
        m_adv   = (s1_occ != 0) && (!s2_full || r);
        s1_free = (s1_occ == 0) || m_adv;
        exp_grant = -1;
        if (s1_free)
            for (int i = 0; i < 4; i++)
                if (exp_grant < 0 && v[(ptr + i) % 4]) exp_grant = (ptr + i) % 4;
        exp_ready = (exp_grant >= 0) ? (4'b0001 << exp_grant) : 4'b0000;
    endtask

    task automatic step;
        bit popped;
        @(posedge clk_i);
        popped = s2_full && rsp_ready_i;
        if (popped) begin
            void'(q_id.pop_front());
            void'(q_dat.pop_front());
        end
        s2_full = m_adv ? 1'b1 : (popped ? 1'b0 : s2_full);
        if (exp_grant >= 0) begin
            q_id.push_back(exp_grant);
            q_dat.push_back(f_tanh(16'(req_data_i >> (exp_grant * 16))));
            ptr = (exp_grant + 1) % 4;
        end
    endtask

    task automatic do_reset;
        @(negedge clk_i);
        rst_ni = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        req_valid_i = 4'hF;
        rsp_ready_i = 1'b1;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready_o); end
        n_cmp++; if (tanh_in_o !== 16'h0) begin n_fail++; $display("FAIL reset_tanh_in got %h want 0000", tanh_in_o); end
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
        n_cmp++; if (rsp_data_o !== 8'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h want 00", rsp_data_o); end
        n_cmp++; if (rsp_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        req_valid_i = '0;
    endtask

    task automatic test_single;
        do_reset();
        setup(4'b0001, 64'h1234, 1'b1);
        n_cmp++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b want 0001", req_ready_o); end
        step();
        setup(4'b0000, 64'h0, 1'b1);
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", rsp_valid_o); end
        n_cmp++; if (tanh_in_o !== 16'h1234) begin n_fail++; $display("FAIL single_tanh_in got %h want 1234", tanh_in_o); end
        step();
        setup(4'b0000, 64'h0, 1'b1);
        n_cmp++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", rsp_valid_o); end
        n_cmp++; if (rsp_data_o !== 8'h12) begin n_fail++; $display("FAIL single_data got %h want 12", rsp_data_o); end
        n_cmp++; if (rsp_id_o !== 2'd0) begin n_fail++; $display("FAIL single_id got %0d want 0", rsp_id_o); end
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy_o); end
        step();
        setup(4'b0000, 64'h0, 1'b1);
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_done got %b want 0", rsp_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", busy_o); end
        step();
    endtask

    task automatic test_round_robin;
        logic [63:0] d = 64'h4400_3300_2200_1100;
        logic [3:0]  want;
        logic [7:0]  wdat;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            setup(4'hF, d, 1'b1);
            want = 4'b0001 << (i % 4);
            n_cmp++; if (req_ready_o !== want) begin n_fail++; $display("FAIL rr_grant%0d got %b want %b", i, req_ready_o, want); end
            if (i >= 2) begin
                wdat = 8'(((i - 2) % 4 + 1) * 8'h11);
                n_cmp++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL rr_valid%0d got %b want 1", i, rsp_valid_o); end
                n_cmp++; if (rsp_id_o !== 2'((i - 2) % 4)) begin n_fail++; $display("FAIL rr_id%0d got %0d want %0d", i, rsp_id_o, (i - 2) % 4); end
                n_cmp++; if (rsp_data_o !== wdat) begin n_fail++; $display("FAIL rr_data%0d got %h want %h", i, rsp_data_o, wdat); end
            end
            step();
        end
        repeat (3) begin setup(4'b0, d, 1'b1); step(); end
    endtask

    task automatic test_backpressure;
        logic [63:0] d = 64'h0000_C3D4_A1B2_0000;
        int grants = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            setup(4'b0110, d, 1'b0);
            if (req_ready_o !== 4'b0) grants++;
            n_cmp++; if (req_ready_o !== exp_ready) begin n_fail++; $display("FAIL bp_ready%0d got %b want %b", i, req_ready_o, exp_ready); end
            if (i >= 2) begin
                n_cmp++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d got %b want 1", i, rsp_valid_o); end
                n_cmp++; if (rsp_id_o !== 2'd1) begin n_fail++; $display("FAIL bp_id%0d got %0d want 1", i, rsp_id_o); end
                n_cmp++; if (rsp_data_o !== 8'hA1) begin n_fail++; $display("FAIL bp_data%0d got %h want a1", i, rsp_data_o); end
            end
            step();
        end
        n_cmp++; if (grants !== 2) begin n_fail++; $display("FAIL bp_grants got %0d want 2", grants); end
        setup(4'b0, d, 1'b1);
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd1 || rsp_data_o !== 8'hA1) begin
            n_fail++; $display("FAIL bp_drain1 got v%b id%0d %h want v1 id1 a1", rsp_valid_o, rsp_id_o, rsp_data_o); end
        step();
        setup(4'b0, d, 1'b1);
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd2 || rsp_data_o !== 8'hC3) begin
            n_fail++; $display("FAIL bp_drain2 got v%b id%0d %h want v1 id2 c3", rsp_valid_o, rsp_id_o, rsp_data_o); end
        step();
        setup(4'b0, d, 1'b1);
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", rsp_valid_o); end
        step();
    endtask

    task automatic test_wrap;
        logic [63:0] d = 64'h7700_6600_5500_4400;
        logic [3:0]  vs [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b1111};
        logic [3:0]  gs [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            setup(vs[i], d, 1'b1);
            n_cmp++; if (req_ready_o !== gs[i]) begin n_fail++; $display("FAIL wrap_grant%0d got %b want %b", i, req_ready_o, gs[i]); end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            setup(4'b0, d, 1'b1);
            if (s2_full) begin
                n_cmp++; if (rsp_id_o !== 2'(q_id[0]) || rsp_data_o !== q_dat[0]) begin
                    n_fail++; $display("FAIL wrap_rsp%0d got id%0d %h want id%0d %h", i, rsp_id_o, rsp_data_o, q_id[0], q_dat[0]); end
            end
            step();
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] d = 64'h0000_0000_6600_5500;
        do_reset();
        setup(4'b0011, d, 1'b0); step();
        setup(4'b0011, d, 1'b0); step();
        setup(4'b0011, d, 1'b0);
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL mid_full got %b want 1", busy_o); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0) begin n_fail++; $display("FAIL mid_ready got %b want 0000", req_ready_o); end
        n_cmp++; if (tanh_in_o !== 16'h0) begin n_fail++; $display("FAIL mid_tanh_in got %h want 0000", tanh_in_o); end
        n_cmp++; if (rsp_valid_o !== 1'b0 || rsp_data_o !== 8'h0 || rsp_id_o !== 2'd0) begin
            n_fail++; $display("FAIL mid_rsp got v%b id%0d %h want all zero", rsp_valid_o, rsp_id_o, rsp_data_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy_o); end
        model_reset();
        req_valid_i = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setup(4'b0, 64'h0, 1'b1);
            n_cmp++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL mid_stale%0d got v%b busy%b want 0 0", i, rsp_valid_o, busy_o); end
            step();
        end
        setup(4'b0100, 64'h0000_3e00_0000_0000, 1'b1);
        n_cmp++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL mid_grant got %b want 0100", req_ready_o); end
        step();
        setup(4'b0, 64'h0, 1'b1); step();
        setup(4'b0, 64'h0, 1'b1);
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd2 || rsp_data_o !== 8'h3e) begin
            n_fail++; $display("FAIL mid_rsp2 got v%b id%0d %h want v1 id2 3e", rsp_valid_o, rsp_id_o, rsp_data_o); end
        step();
    endtask

    task automatic test_random;
        int acc = 0;
        int ans = 0;
        logic r;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            r = ($urandom_range(0, 3) != 0);
            setup(4'($urandom_range(0, 15)), {$urandom(), $urandom()}, r);
            acc += $countones(req_valid_i & req_ready_o);
            if (rsp_valid_o && rsp_ready_i) ans++;
            n_cmp++; if (req_ready_o !== exp_ready) begin n_fail++;
                if (n_fail < 20) $display("FAIL rnd_ready c%0d got %b want %b", c, req_ready_o, exp_ready); end
            n_cmp++; if (rsp_valid_o !== s2_full) begin n_fail++;
                if (n_fail < 20) $display("FAIL rnd_valid c%0d got %b want %b", c, rsp_valid_o, s2_full); end
            n_cmp++; if (busy_o !== (q_id.size() != 0)) begin n_fail++;
                if (n_fail < 20) $display("FAIL rnd_busy c%0d got %b want %b", c, busy_o, q_id.size() != 0); end
            if (s2_full) begin
                n_cmp++; if (rsp_id_o !== 2'(q_id[0]) || rsp_data_o !== q_dat[0]) begin n_fail++;
                    if (n_fail < 20) $display("FAIL rnd_rsp c%0d got id%0d %h want id%0d %h", c, rsp_id_o, rsp_data_o, q_id[0], q_dat[0]); end
            end
            step();
        end
        for (int c = 0; c < 4; c++) begin
            setup(4'b0, 64'h0, 1'b1);
            if (rsp_valid_o) ans++;
            if (s2_full) begin
                n_cmp++; if (rsp_id_o !== 2'(q_id[0]) || rsp_data_o !== q_dat[0]) begin n_fail++;
                    $display("FAIL rnd_drain%0d got id%0d %h want id%0d %h", c, rsp_id_o, rsp_data_o, q_id[0], q_dat[0]); end
            end
            step();
        end
        setup(4'b0, 64'h0, 1'b1);
        n_cmp++; if (acc !== ans) begin n_fail++; $display("FAIL rnd_count accepted %0d answered %0d", acc, ans); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rnd_idle got %b want 0", busy_o); end
        step();
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = '0;
        req_data_i = '0;
        rsp_ready_i = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
